// File: rtl/ahb_sram_slave_pkg.sv
// Shared AHB-Lite encodings and FSM state type for the SRAM slave.
package ahb_sram_slave_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } state_e;

  // NONSEQ and SEQ both carry a real transfer; IDLE and BUSY do not.
  function automatic logic trans_active(input logic [1:0] htrans);
    return htrans[1];
  endfunction

endpackage

// File: rtl/ahb_sram_slave_mem.sv
// Word-organised SRAM with per-byte write enables and an asynchronous read port.
module ahb_sram_slave_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int IDX_W      = 10
) (
  input  logic                    clk_i,
  input  logic                    we_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [IDX_W-1:0]        addr_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic [DATA_WIDTH-1:0]   rdata_o
);

  localparam int NBYTES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (be_i[b]) mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: address-phase capture, response FSM, byte-lane decode.
// Optional wait-state insertion is enabled by defining AHB_SLAVE_WAIT_EN.
module ahb_sram_slave
  import ahb_sram_slave_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [1:0]            HTRANS,
  input  logic                  HMASTERLOCK,
  input  logic                  HREADY,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  output logic                  HRESP,
  output logic                  HREADYout,
  output logic [DATA_WIDTH-1:0] HRDATA
);

  localparam int NBYTES    = DATA_WIDTH / 8;
  localparam int BYTE_BITS = $clog2(NBYTES);
  localparam int IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_dw
    $error("ahb_sram_slave: DATA_WIDTH must be 32 or 64");
  end
  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_ws
    $error("ahb_sram_slave: WAIT_STATES must be 0..15");
  end
  if (ADDR_WIDTH < BYTE_BITS + IDX_W) begin : g_bad_aw
    $error("ahb_sram_slave: ADDR_WIDTH too small for DEPTH");
  end

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [BYTE_BITS-1:0]  off_q, off_d;
  logic [2:0]            size_q, size_d;
  logic                  write_q, write_d;

  logic                  accept;
  logic                  addr_bad;
  logic                  wait_busy;
  logic                  ready_int;
  logic                  data_done;
  logic                  mem_we;
  logic [BYTE_BITS-1:0]  lo_mask;
  logic [NBYTES-1:0]     be;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  unused_ahb;

  assign unused_ahb = ^{HBURST, HPROT, HMASTERLOCK, HTRANS[0]};

  assign accept = HSEL && HREADY && trans_active(HTRANS);

  // Bad if past the array, wider than the bus, or not aligned to its own size.
  always_comb begin
    lo_mask = '0;
    for (int i = 0; i < BYTE_BITS; i++) begin
      if (i < int'(HSIZE)) lo_mask[i] = 1'b1;
    end
    addr_bad = ((HADDR >> BYTE_BITS) >= ADDR_WIDTH'(DEPTH)) ||
               (int'(HSIZE) > BYTE_BITS) ||
               ((HADDR[BYTE_BITS-1:0] & lo_mask) != '0);
  end

`ifdef AHB_SLAVE_WAIT_EN
  logic [3:0] wcnt_q, wcnt_d;

  always_comb begin
    wcnt_d = wcnt_q;
    if (ready_int && accept && !addr_bad) wcnt_d = 4'(WAIT_STATES);
    else if (wcnt_q != 4'd0)              wcnt_d = wcnt_q - 4'd1;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) wcnt_q <= 4'd0;
    else          wcnt_q <= wcnt_d;
  end

  assign wait_busy = (wcnt_q != 4'd0);
`else
  assign wait_busy = 1'b0;
`endif

  assign ready_int = (state_q != ST_ERR1) && !((state_q == ST_DATA) && wait_busy);
  assign data_done = (state_q == ST_DATA) && ready_int;

  // A new address phase is only taken while the current data phase completes.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    off_d   = off_q;
    size_d  = size_q;
    write_d = write_q;
    if (state_q == ST_ERR1) begin
      state_d = ST_ERR2;
    end else if (ready_int) begin
      if (accept) begin
        state_d = addr_bad ? ST_ERR1 : ST_DATA;
        idx_d   = HADDR[BYTE_BITS +: IDX_W];
        off_d   = HADDR[BYTE_BITS-1:0];
        size_d  = HSIZE;
        write_d = HWRITE;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      off_q   <= '0;
      size_q  <= 3'd0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      off_q   <= off_d;
      size_q  <= size_d;
      write_q <= write_d;
    end
  end

  always_comb begin
    be = '0;
    for (int i = 0; i < NBYTES; i++) begin
      if (i >= int'(off_q) && i < int'(off_q) + (1 << int'(size_q))) be[i] = 1'b1;
    end
  end

  assign mem_we = data_done && write_q;

  ahb_sram_slave_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .IDX_W      (IDX_W)
  ) u_mem (
    .clk_i   (HCLK),
    .we_i    (mem_we),
    .be_i    (be),
    .addr_i  (idx_q),
    .wdata_i (HWDATA),
    .rdata_o (rdata)
  );

  assign HREADYout = ready_int;
  assign HRESP     = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  assign HRDATA    = (data_done && !write_q) ? rdata : '0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench for ahb_sram_slave (DATA_WIDTH=32, DEPTH=1024, WAIT_STATES=2).
module tb_ahb_sram_slave;
  import ahb_sram_slave_pkg::*;

`ifdef AHB_SLAVE_WAIT_EN
  localparam int EXP_WS = 2;
`else
  localparam int EXP_WS = 0;
`endif

  logic        HCLK;
  logic        HRESETn;
  logic        HSEL;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;
  logic        HMASTERLOCK;
  logic        HREADY;
  logic [31:0] HWDATA;
  logic        HRESP;
  logic        HREADYout;
  logic [31:0] HRDATA;
  logic        hready_ovr;

  // Single-slave bus: HREADY is the slave's own ready unless another slave stalls.
  assign HREADY = hready_ovr ? 1'b0 : HREADYout;

  ahb_sram_slave #(
    .DATA_WIDTH  (32),
    .ADDR_WIDTH  (32),
    .DEPTH       (1024),
    .WAIT_STATES (2)
  ) dut (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .HSEL        (HSEL),
    .HADDR       (HADDR),
    .HWRITE      (HWRITE),
    .HSIZE       (HSIZE),
    .HBURST      (HBURST),
    .HPROT       (HPROT),
    .HTRANS      (HTRANS),
    .HMASTERLOCK (HMASTERLOCK),
    .HREADY      (HREADY),
    .HWDATA      (HWDATA),
    .HRESP       (HRESP),
    .HREADYout   (HREADYout),
    .HRDATA      (HRDATA)
  );

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  logic        b_wr   [8];
  logic [31:0] b_addr [8];
  logic [2:0]  b_size [8];
  logic [31:0] b_data [8];
  logic        b_seq  [8];
  logic [31:0] r_data [8];
  logic        r_resp [8];
  logic        r_rdy0 [8];
  logic        r_resp0[8];
  int          r_waits[8];

  task automatic set_beat(input int i, input logic wr, input logic [31:0] a,
                          input logic [2:0] sz, input logic [31:0] d, input logic sq);
    b_wr[i] = wr; b_addr[i] = a; b_size[i] = sz; b_data[i] = d; b_seq[i] = sq;
  endtask

  // Pipelined master: called at a falling edge, returns at a falling edge.
  task automatic run(input int n);
    int nxt, dp, cyc, guard;
    logic rdy;
    nxt = 0; dp = -1; cyc = 0; guard = 0;
    for (int i = 0; i < 8; i++) begin
      r_data[i] = '0; r_resp[i] = 1'b0; r_rdy0[i] = 1'b0; r_resp0[i] = 1'b0; r_waits[i] = 0;
    end
    while ((nxt < n || dp >= 0) && guard < 200) begin
      if (dp >= 0 && b_wr[dp]) HWDATA = b_data[dp];
      if (nxt < n) begin
        HSEL = 1'b1; HTRANS = b_seq[nxt] ? HTRANS_SEQ : HTRANS_NONSEQ;
        HADDR = b_addr[nxt]; HWRITE = b_wr[nxt]; HSIZE = b_size[nxt];
      end else begin
        HSEL = 1'b0; HTRANS = HTRANS_IDLE;
      end
      #1;
      rdy = HREADYout;
      if (dp >= 0) begin
        if (cyc == 0) begin r_rdy0[dp] = rdy; r_resp0[dp] = HRESP; end
        if (!rdy) r_waits[dp]++;
        else begin r_data[dp] = HRDATA; r_resp[dp] = HRESP; end
      end
      if (rdy) begin
        dp = (nxt < n) ? nxt : -1;
        if (nxt < n) nxt++;
        cyc = 0;
      end else begin
        cyc++;
      end
      @(negedge HCLK);
      guard++;
    end
    HSEL = 1'b0; HTRANS = HTRANS_IDLE;
    if (guard >= 200) check("run_timeout", 64'(guard), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    HRESETn = 1'b0; HSEL = 1'b0; HADDR = '0; HWRITE = 1'b0; HSIZE = HSIZE_WORD;
    HBURST = 3'd0; HPROT = 4'd0; HTRANS = HTRANS_IDLE; HMASTERLOCK = 1'b0;
    HWDATA = '0; hready_ovr = 1'b0;

    #1;
    check("rst_ready", 64'(HREADYout), 64'd1);
    check("rst_resp",  64'(HRESP),     64'd0);
    check("rst_rdata", 64'(HRDATA),    64'd0);
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;

    // Back-to-back write then read of the same word.
    set_beat(0, 1'b1, 32'h10, HSIZE_WORD, 32'hDEADBEEF, 1'b0);
    set_beat(1, 1'b0, 32'h10, HSIZE_WORD, 32'h0, 1'b0);
    run(2);
    check("raw_data",   64'(r_data[1]),  64'hDEADBEEF);
    check("raw_resp",   64'(r_resp[1]),  64'd0);
    check("raw_wwait",  64'(r_waits[0]), 64'(EXP_WS));
    check("raw_rwait",  64'(r_waits[1]), 64'(EXP_WS));

    // Byte and halfword lane writes.
    set_beat(0, 1'b1, 32'h10, HSIZE_WORD, 32'h11223344, 1'b0);
    set_beat(1, 1'b1, 32'h13, HSIZE_BYTE, 32'hAA000000, 1'b0);
    set_beat(2, 1'b1, 32'h14, HSIZE_WORD, 32'h01020304, 1'b0);
    set_beat(3, 1'b1, 32'h16, HSIZE_HALF, 32'hCAFE0000, 1'b0);
    set_beat(4, 1'b0, 32'h10, HSIZE_WORD, 32'h0, 1'b0);
    set_beat(5, 1'b0, 32'h14, HSIZE_WORD, 32'h0, 1'b0);
    run(6);
    check("byte_lane3", 64'(r_data[4]), 64'hAA223344);
    check("half_upper", 64'(r_data[5]), 64'hCAFE0304);

    // INCR4 write then INCR4 read.
    for (int i = 0; i < 4; i++) set_beat(i, 1'b1, 32'(i*4), HSIZE_WORD, 32'(i+1), i != 0);
    run(4);
    for (int i = 0; i < 4; i++) set_beat(i, 1'b0, 32'(i*4), HSIZE_WORD, 32'h0, i != 0);
    run(4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("incr4_data%0d", i), 64'(r_data[i]),  64'(i+1));
      check($sformatf("incr4_wait%0d", i), 64'(r_waits[i]), 64'(EXP_WS));
    end

    // Out-of-range read: two-cycle ERROR.
    set_beat(0, 1'b0, 32'h1000, HSIZE_WORD, 32'h0, 1'b0);
    run(1);
    check("oor_rdy1",  64'(r_rdy0[0]),  64'd0);
    check("oor_resp1", 64'(r_resp0[0]), 64'd1);
    check("oor_resp2", 64'(r_resp[0]),  64'd1);
    check("oor_rdata", 64'(r_data[0]),  64'd0);
    check("oor_waits", 64'(r_waits[0]), 64'd1);

    // Erroring writes (alias of word 0, misaligned, oversize) must not touch memory.
    set_beat(0, 1'b1, 32'h1000, HSIZE_WORD,  32'hBADBAD00, 1'b0);
    set_beat(1, 1'b1, 32'h11,   HSIZE_HALF,  32'hFFFFFFFF, 1'b0);
    set_beat(2, 1'b0, 32'h11,   HSIZE_WORD,  32'h0, 1'b0);
    set_beat(3, 1'b1, 32'h10,   HSIZE_DWORD, 32'hFFFFFFFF, 1'b0);
    set_beat(4, 1'b0, 32'h0,    HSIZE_WORD,  32'h0, 1'b0);
    set_beat(5, 1'b0, 32'h10,   HSIZE_WORD,  32'h0, 1'b0);
    run(6);
    for (int i = 0; i < 4; i++) check($sformatf("err_resp1_%0d", i), 64'(r_resp0[i]), 64'd1);
    check("err_w0_kept",  64'(r_data[4]), 64'd1);
    check("err_w10_kept", 64'(r_data[5]), 64'hAA223344);
    check("err_ok_resp",  64'(r_resp[5]), 64'd0);

    // IDLE while selected, then NONSEQ while unselected: no access.
    HSEL = 1'b1; HTRANS = HTRANS_IDLE; HWRITE = 1'b1; HADDR = 32'h0; HSIZE = HSIZE_WORD;
    #1;
    check("idle_ready", 64'(HREADYout), 64'd1);
    check("idle_resp",  64'(HRESP),     64'd0);
    @(negedge HCLK);
    HWDATA = 32'hFFFFFFFF; HSEL = 1'b0; HTRANS = HTRANS_NONSEQ; HADDR = 32'h4;
    #1;
    check("unsel_ready", 64'(HREADYout), 64'd1);
    check("unsel_resp",  64'(HRESP),     64'd0);
    @(negedge HCLK);
    HTRANS = HTRANS_IDLE;
    #1;
    check("unsel_ready2", 64'(HREADYout), 64'd1);
    @(negedge HCLK);

    // Address phase held while HREADY is low must not be accepted.
    hready_ovr = 1'b1; HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HWRITE = 1'b1; HADDR = 32'h8;
    @(negedge HCLK);
    hready_ovr = 1'b0; HSEL = 1'b0; HTRANS = HTRANS_IDLE; HWDATA = 32'hFFFFFFFF;
    @(negedge HCLK);
    set_beat(0, 1'b0, 32'h0, HSIZE_WORD, 32'h0, 1'b0);
    set_beat(1, 1'b0, 32'h4, HSIZE_WORD, 32'h0, 1'b0);
    set_beat(2, 1'b0, 32'h8, HSIZE_WORD, 32'h0, 1'b0);
    run(3);
    check("idle_w0_kept",  64'(r_data[0]), 64'd1);
    check("unsel_w4_kept", 64'(r_data[1]), 64'd2);
    check("hrdy0_w8_kept", 64'(r_data[2]), 64'd3);

    // Reset in the middle of a write data phase.
    set_beat(0, 1'b1, 32'h40, HSIZE_WORD, 32'h12345678, 1'b0);
    run(1);
    HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HWRITE = 1'b1; HADDR = 32'h40; HSIZE = HSIZE_WORD;
    @(negedge HCLK);
    HWDATA = 32'h55555555; HSEL = 1'b0; HTRANS = HTRANS_IDLE;
    #1;
    HRESETn = 1'b0;
    #1;
    check("mid_rst_ready", 64'(HREADYout), 64'd1);
    check("mid_rst_resp",  64'(HRESP),     64'd0);
    check("mid_rst_rdata", 64'(HRDATA),    64'd0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    set_beat(0, 1'b0, 32'h40, HSIZE_WORD, 32'h0, 1'b0);
    run(1);
    check("mid_rst_kept", 64'(r_data[0]), 64'h12345678);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
